// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch lap/split path.
package sw_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LAP_W   = 16;

  // Field offsets inside a stored lap word
  localparam int unsigned MIN_LSB = 12;
  localparam int unsigned ST_LSB  = 8;
  localparam int unsigned SU_LSB  = 4;
  localparam int unsigned TEN_LSB = 0;

  typedef enum logic {
    LIVE   = 1'b0,
    RECALL = 1'b1
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min;
    logic [DIGIT_W-1:0] st;
    logic [DIGIT_W-1:0] su;
    logic [DIGIT_W-1:0] ten;
  } lap_word_t;

  // Assemble a lap word from the four live digits
  function automatic lap_word_t pack_lap(input logic [DIGIT_W-1:0] min,
                                         input logic [DIGIT_W-1:0] st,
                                         input logic [DIGIT_W-1:0] su,
                                         input logic [DIGIT_W-1:0] ten);
    logic [LAP_W-1:0] w;
    w = (LAP_W'(min) << MIN_LSB) | (LAP_W'(st) << ST_LSB)
      | (LAP_W'(su) << SU_LSB) | (LAP_W'(ten) << TEN_LSB);
    return lap_word_t'(w);
  endfunction

endpackage

// File: rtl/lap_regfile.sv
// Lap storage: DEPTH x LAP_W, one write port, one registered read port.
// The read register doubles as the display register: ld_en loads live digits,
// and a same-cycle write to the read address is forwarded.
module lap_regfile
  import sw_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  lap_word_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  input  logic             ld_en,
  input  lap_word_t        ld_data,
  output lap_word_t        rd_data
);

  lap_word_t mem_q [DEPTH];
  lap_word_t rd_data_d;
  lap_word_t rd_data_q;

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data select: live load, then write forwarding, then array
  always_comb begin
    rd_data_d = mem_q[raddr];
    if (we && (waddr == raddr)) rd_data_d = wdata;
    if (ld_en) rd_data_d = ld_data;
  end

  // Read/display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lap_recorder.sv
// Lap/split memory between stopwatch core and display_mux.
// Optional feature macro: LAP_BLINK_EN (blinking decimal point while recalling).
module lap_recorder
  import sw_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = $clog2(DEPTH)
`ifdef LAP_BLINK_EN
  , parameter int unsigned BLINK_CYCLES = 25_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lap_p,
  input  logic               view_p,
  input  logic               clear_p,
  input  logic [DIGIT_W-1:0] live_min,
  input  logic [DIGIT_W-1:0] live_st,
  input  logic [DIGIT_W-1:0] live_su,
  input  logic [DIGIT_W-1:0] live_ten,
  output logic [DIGIT_W-1:0] hex3,
  output logic [DIGIT_W-1:0] hex2,
  output logic [DIGIT_W-1:0] hex1,
  output logic [DIGIT_W-1:0] hex0,
  output logic               recall,
  output logic [IDX_W:0]     lap_num,
  output logic [IDX_W:0]     lap_cnt,
  output logic               overflow,
  output logic               dp_blink
);

  localparam int unsigned      CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] lap_cnt_q, lap_cnt_d;
  logic [CNT_W-1:0] lap_num_q, lap_num_d;
  logic             overflow_q, overflow_d;
  logic             dp_blink_q, dp_blink_d;
  logic             we_c;
  lap_word_t        live_word_c;
  lap_word_t        rd_word;

  assign live_word_c = pack_lap(live_min, live_st, live_su, live_ten);

  // Next-state: clear beats lap beats view; a lap in LIVE may still enter recall
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lap_cnt_d  = lap_cnt_q;
    lap_num_d  = lap_num_q;
    overflow_d = overflow_q;
    we_c       = 1'b0;
    if (clear_p) begin
      state_d    = LIVE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      lap_cnt_d  = '0;
      lap_num_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (lap_p) begin
        we_c     = 1'b1;
        wr_ptr_d = wr_ptr_q + IDX_W'(1);
        if (lap_cnt_q == CNT_FULL) overflow_d = 1'b1;
        else                       lap_cnt_d  = lap_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        LIVE: begin
          if (view_p && (lap_cnt_d != '0)) begin
            state_d   = RECALL;
            rd_ptr_d  = wr_ptr_d - IDX_W'(1);
            lap_num_d = CNT_W'(1);
          end
        end
        RECALL: begin
          if (lap_p) begin
            // Display stays on the same slot, which is now one lap older
            if (lap_num_q < lap_cnt_d) lap_num_d = lap_num_q + CNT_W'(1);
          end else if (view_p) begin
            if (lap_num_q < lap_cnt_q) begin
              rd_ptr_d  = rd_ptr_q - IDX_W'(1);
              lap_num_d = lap_num_q + CNT_W'(1);
            end else begin
              state_d   = LIVE;
              lap_num_d = '0;
            end
          end
        end
        default: state_d = LIVE;
      endcase
    end
  end

`ifdef LAP_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

  // Blink timer: lit on recall entry, toggles every BLINK_CYCLES, dark in LIVE
  always_comb begin
    blink_cnt_d = '0;
    dp_blink_d  = 1'b0;
    if (state_d == RECALL) begin
      if (state_q == LIVE) begin
        dp_blink_d = 1'b1;
      end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
        dp_blink_d = ~dp_blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        dp_blink_d  = dp_blink_q;
      end
    end
  end

  // Blink counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt_q <= '0;
    else        blink_cnt_q <= blink_cnt_d;
  end
`else
  // Decimal point simply mirrors recall
  always_comb begin
    dp_blink_d = (state_d == RECALL);
  end
`endif

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LIVE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lap_cnt_q  <= '0;
      lap_num_q  <= '0;
      overflow_q <= 1'b0;
      dp_blink_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lap_cnt_q  <= lap_cnt_d;
      lap_num_q  <= lap_num_d;
      overflow_q <= overflow_d;
      dp_blink_q <= dp_blink_d;
    end
  end

  lap_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we_c),
    .waddr   (wr_ptr_q),
    .wdata   (live_word_c),
    .raddr   (rd_ptr_d),
    .ld_en   (state_d == LIVE),
    .ld_data (live_word_c),
    .rd_data (rd_word)
  );

  assign hex3     = rd_word.min;
  assign hex2     = rd_word.st;
  assign hex1     = rd_word.su;
  assign hex0     = rd_word.ten;
  assign recall   = (state_q == RECALL);
  assign lap_num  = lap_num_q;
  assign lap_cnt  = lap_cnt_q;
  assign overflow = overflow_q;
  assign dp_blink = dp_blink_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed bench for lap_recorder (DEPTH=4, default build) with expectation queue.
module tb_lap_recorder;

  typedef struct packed {
    logic [15:0] hex;
    logic        rec;
    logic [2:0]  num;
    logic [2:0]  cnt;
    logic        ovf;
    logic        dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lap_p = 1'b0;
  logic       view_p = 1'b0;
  logic       clear_p = 1'b0;
  logic [3:0] live_min = '0, live_st = '0, live_su = '0, live_ten = '0;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic       recall;
  logic [2:0] lap_num;
  logic [2:0] lap_cnt;
  logic       overflow;
  logic       dp_blink;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lap_recorder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lap_p    (lap_p),
    .view_p   (view_p),
    .clear_p  (clear_p),
    .live_min (live_min),
    .live_st  (live_st),
    .live_su  (live_su),
    .live_ten (live_ten),
    .hex3     (hex3),
    .hex2     (hex2),
    .hex1     (hex1),
    .hex0     (hex0),
    .recall   (recall),
    .lap_num  (lap_num),
    .lap_cnt  (lap_cnt),
    .overflow (overflow),
    .dp_blink (dp_blink)
  );

  function automatic exp_t mk(input logic [15:0] h, input logic r,
                              input logic [2:0] n, input logic [2:0] c, input logic o);
    exp_t e;
    e.hex = h; e.rec = r; e.num = n; e.cnt = c; e.ovf = o; e.dp = r;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare all outputs against it
  task automatic check_top();
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hex",      {hex3, hex2, hex1, hex0}, e.hex);
      chk("recall",   16'(recall),   16'(e.rec));
      chk("lap_num",  16'(lap_num),  16'(e.num));
      chk("lap_cnt",  16'(lap_cnt),  16'(e.cnt));
      chk("overflow", 16'(overflow), 16'(e.ovf));
      chk("dp_blink", 16'(dp_blink), 16'(e.dp));
    end
  endtask

  // Drive one cycle of pulses and live time, expect e after the edge
  task automatic step(input logic lap, input logic view, input logic clr,
                      input logic [15:0] live, input exp_t e);
    lap_p   = lap;
    view_p  = view;
    clear_p = clr;
    {live_min, live_st, live_su, live_ten} = live;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    lap_p   = 1'b0;
    view_p  = 1'b0;
    clear_p = 1'b0;
    check_top();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst_n is held low
    #12;
    sb_q.push_back(mk(16'h0000, 1'b0, 3'd0, 3'd0, 1'b0));
    check_top();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Live pass-through, 1:23.4
    step(1'b0, 1'b0, 1'b0, 16'h1234, mk(16'h1234, 1'b0, 3'd0, 3'd0, 1'b0));

    // Two laps, recall newest then older, then back to live
    step(1'b1, 1'b0, 1'b0, 16'h0051, mk(16'h0051, 1'b0, 3'd0, 3'd1, 1'b0));
    step(1'b1, 1'b0, 1'b0, 16'h0097, mk(16'h0097, 1'b0, 3'd0, 3'd2, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0100, mk(16'h0097, 1'b1, 3'd1, 3'd2, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0100, mk(16'h0051, 1'b1, 3'd2, 3'd2, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0100, mk(16'h0100, 1'b0, 3'd0, 3'd2, 1'b0));

    // Clear, then view with no laps is ignored
    step(1'b0, 1'b0, 1'b1, 16'h0200, mk(16'h0200, 1'b0, 3'd0, 3'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0200, mk(16'h0200, 1'b0, 3'd0, 3'd0, 1'b0));

    // Five laps into four slots: saturating count, sticky overflow
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b0, 1'b0, 16'(i),
           mk(16'(i), 1'b0, 3'd0, 3'((i <= 4) ? i : 4), 1'(i == 5)));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0005, 1'b1, 3'd1, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0004, 1'b1, 3'd2, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0003, 1'b1, 3'd3, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0002, 1'b1, 3'd4, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0300, 1'b0, 3'd0, 3'd4, 1'b1));

    // Lap while recalling: display keeps its slot, age advances
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0005, 1'b1, 3'd1, 3'd4, 1'b1));
    step(1'b1, 1'b0, 1'b0, 16'h0006, mk(16'h0005, 1'b1, 3'd2, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0004, 1'b1, 3'd3, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0003, 1'b1, 3'd4, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0300, 1'b0, 3'd0, 3'd4, 1'b1));

    // Lap overwrites the slot being shown: new content, age saturates
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0006, 1'b1, 3'd1, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0005, 1'b1, 3'd2, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0004, 1'b1, 3'd3, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0003, 1'b1, 3'd4, 3'd4, 1'b1));
    step(1'b1, 1'b0, 1'b0, 16'h0007, mk(16'h0007, 1'b1, 3'd4, 3'd4, 1'b1));
    step(1'b0, 1'b1, 1'b0, 16'h0300, mk(16'h0300, 1'b0, 3'd0, 3'd4, 1'b1));

    // Clear drops overflow; lap+view together recalls the just-captured lap
    step(1'b0, 1'b0, 1'b1, 16'h0400, mk(16'h0400, 1'b0, 3'd0, 3'd0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 16'h2345, mk(16'h2345, 1'b1, 3'd1, 3'd1, 1'b0));
    // lap+view in recall: lap wins, view dropped
    step(1'b1, 1'b1, 1'b0, 16'h0011, mk(16'h2345, 1'b1, 3'd2, 3'd2, 1'b0));

    // clear+lap in recall: back to live, nothing stored
    step(1'b1, 1'b0, 1'b1, 16'h0999, mk(16'h0999, 1'b0, 3'd0, 3'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0999, mk(16'h0999, 1'b0, 3'd0, 3'd0, 1'b0));

    // Asynchronous reset between edges while recalling
    step(1'b1, 1'b1, 1'b0, 16'h0555, mk(16'h0555, 1'b1, 3'd1, 3'd1, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk(16'h0000, 1'b0, 3'd0, 3'd0, 1'b0));
    check_top();
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0678, mk(16'h0678, 1'b0, 3'd0, 3'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 16'h0678, mk(16'h0678, 1'b0, 3'd0, 3'd0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
